// File: rtl/en_arb_pkg.sv
// ============================================================================
// Module   : en_arb_pkg
// Brief    : Shared types and helpers for the enabled-register write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package en_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/en_dff_bank.sv
// ============================================================================
// Module   : en_dff_bank
// Brief    : DW-bit enabled D register, synchronous active-high reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module en_dff_bank #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/en_reg_write_arbiter.sv
// ============================================================================
// Module   : en_reg_write_arbiter
// Brief    : Round-robin write arbiter in front of a shared enabled register.
//            Optional burst lock (held grant, MAX_LOCK writes) with ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module en_reg_write_arbiter
    import en_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
`ifdef ARB_LOCK_EN
    parameter int MAX_LOCK = 4,
`endif
    parameter int DW       = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DW-1:0]         wdata,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0]            lock,
`endif
    output logic [N_REQ-1:0]            gnt,
    output logic [idx_w(N_REQ)-1:0]     gnt_id,
    output logic                        busy,
    output logic [DW-1:0]               q,
    output logic                        upd
);

    localparam int c_IW = idx_w(N_REQ);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [c_IW-1:0]    r_gnt_id;
    logic [c_IW-1:0]    w_gnt_id_nxt;
    logic [c_IW-1:0]    r_ptr;
    logic [c_IW-1:0]    w_ptr_nxt;
    logic [N_REQ-1:0]   w_cand;
    logic               w_win_vld;
    logic [c_IW-1:0]    w_win_id;
    logic               w_hold;
    logic               w_en;
    logic [DW-1:0]      w_d;
    logic               r_upd;

    // The current grantee sits out the next arbitration (self-mask).
    assign w_cand = (r_state == GRANT) ? (req & ~r_gnt) : req;

    always_comb begin
        int j;
        w_win_vld = 1'b0;
        w_win_id  = '0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!w_win_vld && w_cand[j]) begin
                w_win_vld = 1'b1;
                w_win_id  = c_IW'(j);
            end
        end
    end

`ifdef ARB_LOCK_EN
    localparam int c_LW = $clog2(MAX_LOCK + 1);

    logic [c_LW-1:0] r_lock_cnt;

    // r_lock_cnt counts writes already issued in the current held grant.
    assign w_hold = (r_state == GRANT) && lock[r_gnt_id] && req[r_gnt_id]
                    && (r_lock_cnt < c_LW'(MAX_LOCK));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_cnt <= '0;
        end else if (w_hold) begin
            r_lock_cnt <= r_lock_cnt + c_LW'(1);
        end else if (w_win_vld) begin
            r_lock_cnt <= c_LW'(1);
        end
    end
`else
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        if (w_hold) begin
            w_state_nxt = GRANT;
        end else if (w_win_vld) begin
            w_state_nxt            = GRANT;
            w_gnt_nxt              = '0;
            w_gnt_nxt[w_win_id]    = 1'b1;
            w_gnt_id_nxt           = w_win_id;
            w_ptr_nxt              = (int'(w_win_id) == N_REQ - 1) ? '0
                                                                   : w_win_id + c_IW'(1);
        end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_upd    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_ptr    <= w_ptr_nxt;
            r_upd    <= w_en;
        end
    end

    assign w_en = (r_state == GRANT);
    assign w_d  = wdata[int'(r_gnt_id)*DW +: DW];

    en_dff_bank #(
        .DW (DW)
    ) u_dff_bank (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .d     (w_d),
        .q     (q)
    );

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = (r_state == GRANT);
    assign upd    = r_upd;

endmodule

`default_nettype wire

// File: tb/tb_en_reg_write_arbiter.sv
// ============================================================================
// Module   : tb_en_reg_write_arbiter
// Brief    : Directed self-checking bench for en_reg_write_arbiter (N_REQ=4, DW=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_en_reg_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  lock;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        busy;
    logic [7:0]  q;
    logic        upd;

    int n_chk;
    int n_err;

    en_reg_write_arbiter #(
        .N_REQ (4),
        .DW    (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wdata  (wdata),
`ifdef ARB_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .q      (q),
        .upd    (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int i, input logic [7:0] v);
        wdata[i*8 +: 8] = v;
    endtask

    logic [3:0] exp_g2 [6];
    logic [3:0] exp_g6 [7];
    logic       exp_u6 [7];

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = 32'h77665544;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state
        chk_eq("rst_gnt", 32'(gnt), 32'h0);
        chk_eq("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk_eq("rst_busy", 32'(busy), 32'h0);
        chk_eq("rst_q", 32'(q), 32'h0);
        chk_eq("rst_upd", 32'(upd), 32'h0);

        // Scenario 1: single one-cycle request
        set_wd(2, 8'hA5);
        req = 4'b0100;
        step();
        req = 4'b0000;
        chk_eq("s1_gnt", 32'(gnt), 32'h4);
        chk_eq("s1_gnt_id", 32'(gnt_id), 32'h2);
        chk_eq("s1_busy", 32'(busy), 32'h1);
        chk_eq("s1_upd_early", 32'(upd), 32'h0);
        step();
        chk_eq("s1_gnt_off", 32'(gnt), 32'h0);
        chk_eq("s1_q", 32'(q), 32'hA5);
        chk_eq("s1_upd", 32'(upd), 32'h1);
        chk_eq("s1_idle", 32'(busy), 32'h0);
        step();
        chk_eq("s1_upd_off", 32'(upd), 32'h0);
        chk_eq("s1_q_hold", 32'(q), 32'hA5);

        // Scenario 2: all requesting, rotate from ptr=0 after reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_wd(i, 8'(8'h10 + i));
        exp_g2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_eq($sformatf("s2_gnt%0d", i), 32'(gnt), 32'(exp_g2[i]));
            chk_eq($sformatf("s2_busy%0d", i), 32'(busy), 32'h1);
            if (i > 0) begin
                chk_eq($sformatf("s2_q%0d", i), 32'(q), 32'(8'h10 + ((i - 1) % 4)));
                chk_eq($sformatf("s2_upd%0d", i), 32'(upd), 32'h1);
            end
        end
        req = 4'b0000;
        step();
        chk_eq("s2_drain_gnt", 32'(gnt), 32'h0);
        chk_eq("s2_drain_q", 32'(q), 32'h11);
        chk_eq("s2_drain_busy", 32'(busy), 32'h0);

        // Scenario 4: grant to 3, then 1001 held wraps the pointer
        req = 4'b1000;
        step();
        req = 4'b0000;
        chk_eq("s4_g3", 32'(gnt), 32'h8);
        step();
        chk_eq("s4_q3", 32'(q), 32'h13);
        req = 4'b1001;
        step();
        chk_eq("s4_gnt0", 32'(gnt), 32'h1);
        step();
        chk_eq("s4_gnt1", 32'(gnt), 32'h8);
        chk_eq("s4_q1", 32'(q), 32'h10);
        step();
        chk_eq("s4_gnt2", 32'(gnt), 32'h1);
        chk_eq("s4_q2", 32'(q), 32'h13);
        req = 4'b0000;
        step();
        step();

        // Scenario 3: single requester held -> every other cycle
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_eq($sformatf("s3_gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk_eq($sformatf("s3_upd%0d", i), 32'(upd), (i % 2 == 0) ? 32'h0 : 32'h1);
        end
        req = 4'b0000;
        step();
        step();

        // Scenario 5: reset during the grant cycle aborts the write
        set_wd(1, 8'h3C);
        req = 4'b0010;
        step();
        chk_eq("s5_gnt", 32'(gnt), 32'h2);
        reset = 1'b1;
        req   = 4'b0000;
        step();
        reset = 1'b0;
        chk_eq("s5_q", 32'(q), 32'h0);
        chk_eq("s5_gnt_off", 32'(gnt), 32'h0);
        chk_eq("s5_upd", 32'(upd), 32'h0);
        chk_eq("s5_gnt_id", 32'(gnt_id), 32'h0);
        req = 4'b0110;
        step();
        chk_eq("s5_rescan_gnt", 32'(gnt), 32'h2);
        chk_eq("s5_rescan_id", 32'(gnt_id), 32'h1);
        req = 4'b0000;
        step();
        chk_eq("s5_q_after", 32'(q), 32'h3C);
        step();
        step();

        // Scenario 6: lock burst (or plain self-mask without the lock feature)
`ifdef ARB_LOCK_EN
        exp_g6 = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
        exp_u6 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        exp_g6 = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
        exp_u6 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        req  = 4'b0010;
        lock = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            step();
            chk_eq($sformatf("s6_gnt%0d", i), 32'(gnt), 32'(exp_g6[i]));
            chk_eq($sformatf("s6_upd%0d", i), 32'(upd), 32'(exp_u6[i]));
        end
        req  = 4'b0000;
        lock = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
